led_fader: RTL and testbench

Four-channel LED brightness fader that sits directly downstream of the `led_blink` slot core and consumes its 4-bit `dout` blink lines. Each rising or falling edge on an input line starts a linear brightness ramp toward full on or full off; the ramp runs over a software-programmed step interval. Each channel's current brightness is rendered as 8-bit PWM on the LED pins. The block is its own MMIO slot with the standard slot interface.

---
 rtl/led_fader.sv | 155 +++++++++++++++
 tb/tb_led_fader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// ============================================================================
// Module   : led_fader
// Brief    : Four-channel LED fader; blink edges start linear brightness
//            ramps that are rendered as PWM, with an MMIO slot interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_fader #(
    parameter int PWM_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic [3:0]  din,
    output logic [3:0]  dout
);

    localparam logic [PWM_BITS-1:0] c_full    = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] c_lvl_one = PWM_BITS'(1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_UP   = 2'd1,
        S_ON   = 2'd2,
        S_DOWN = 2'd3
    } state_t;

    logic [15:0]         r_step [4];
    logic [3:0]          r_en;
    logic [3:0]          r_din_q;
    logic [PWM_BITS-1:0] r_pwm;
    logic [PWM_BITS-1:0] w_level [4];
    logic [3:0]          w_busy;
    logic                w_unused;

    // Reads are combinational, so the read strobe and upper write bits are unused.
    assign w_unused = ^{read, wr_data[31:16]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                r_step[i] <= '0;
            end
            r_en <= '0;
        end else if (cs && write) begin
            if (addr[4:2] == 3'd0) begin
                r_step[addr[1:0]] <= wr_data[15:0];
            end else if (addr == 5'd4) begin
                r_en <= wr_data[3:0];
            end
        end
    end

    generate
        for (genvar i = 0; i < 4; i++) begin : g_ch
            state_t              r_state;
            logic [PWM_BITS-1:0] r_lvl;
            logic [15:0]         r_pcnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_state <= S_OFF;
                    r_lvl   <= '0;
                    r_pcnt  <= '0;
                end else begin
                    case (r_state)
                        S_OFF: begin
                            if (r_din_q[i]) begin
                                r_state <= S_UP;
                                r_pcnt  <= '0;
                            end
                        end
                        S_ON: begin
                            if (!r_din_q[i]) begin
                                r_state <= S_DOWN;
                                r_pcnt  <= '0;
                            end
                        end
                        S_UP: begin
                            if (!r_din_q[i]) begin
                                r_state <= S_DOWN;
                                r_pcnt  <= '0;
                            end else if (r_pcnt >= r_step[i]) begin
                                r_pcnt <= '0;
                                if (r_lvl >= c_full - c_lvl_one) begin
                                    r_lvl   <= c_full;
                                    r_state <= S_ON;
                                end else begin
                                    r_lvl <= r_lvl + c_lvl_one;
                                end
                            end else begin
                                r_pcnt <= r_pcnt + 16'd1;
                            end
                        end
                        S_DOWN: begin
                            if (r_din_q[i]) begin
                                r_state <= S_UP;
                                r_pcnt  <= '0;
                            end else if (r_pcnt >= r_step[i]) begin
                                r_pcnt <= '0;
                                // Saturate so a reversal before the first up-step cannot wrap.
                                if (r_lvl <= c_lvl_one) begin
                                    r_lvl   <= '0;
                                    r_state <= S_OFF;
                                end else begin
                                    r_lvl <= r_lvl - c_lvl_one;
                                end
                            end else begin
                                r_pcnt <= r_pcnt + 16'd1;
                            end
                        end
                        default: r_state <= S_OFF;
                    endcase
                end
            end

            assign w_level[i] = r_lvl;
            assign w_busy[i]  = (r_state == S_UP) || (r_state == S_DOWN);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_din_q <= '0;
            r_pwm   <= '0;
            dout    <= '0;
        end else begin
            r_din_q <= din;
            r_pwm   <= (r_pwm == c_full - c_lvl_one) ? '0 : r_pwm + c_lvl_one;
            for (int i = 0; i < 4; i++) begin
                dout[i] <= r_en[i] ? (r_pwm < w_level[i]) : r_din_q[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            5'd0, 5'd1, 5'd2, 5'd3:     rd_data = {16'b0, r_step[addr[1:0]]};
            5'd4:                       rd_data = {28'b0, r_en};
            5'd8, 5'd9, 5'd10, 5'd11:   rd_data = 32'(w_level[addr[1:0]]);
            5'd12:                      rd_data = {24'b0, w_busy, r_din_q};
            default:                    rd_data = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_led_fader.sv
// ============================================================================
// Module   : tb_led_fader
// Brief    : Directed, table-driven bench for led_fader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_fader;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [3:0]  din;
    logic [3:0]  dout;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        cs;
        logic        wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    led_fader #(.PWM_BITS(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .din     (din),
        .dout    (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rd_data;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = a;
        wr_data = d;
        tick();
        cs      = 1'b0;
        write   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic [31:0] v;
        logic        ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            rd(5'd12, v);
            if (v == 32'd0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_level(input string name, input logic [4:0] a,
                              input logic [31:0] target, input int budget);
        logic [31:0] v;
        logic        ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            rd(a, v);
            if (v == target) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [4:0]  ra [10];
        int          cnt;

        vecs[0]  = '{1'b1, 1'b1, 5'd2,  32'h0000_1234, 5'd2,  32'h0000_1234};
        vecs[1]  = '{1'b0, 1'b1, 5'd2,  32'h0000_5555, 5'd2,  32'h0000_1234};
        vecs[2]  = '{1'b1, 1'b0, 5'd2,  32'h0000_5555, 5'd2,  32'h0000_1234};
        vecs[3]  = '{1'b1, 1'b1, 5'd9,  32'h0000_00FF, 5'd9,  32'h0000_0000};
        vecs[4]  = '{1'b1, 1'b1, 5'd20, 32'h0000_0077, 5'd4,  32'h0000_0000};
        vecs[5]  = '{1'b1, 1'b1, 5'd20, 32'h0000_0077, 5'd0,  32'h0000_0000};
        vecs[6]  = '{1'b1, 1'b1, 5'd12, 32'h0000_00FF, 5'd12, 32'h0000_0000};
        vecs[7]  = '{1'b1, 1'b1, 5'd0,  32'hABCD_0003, 5'd0,  32'h0000_0003};
        vecs[8]  = '{1'b1, 1'b1, 5'd1,  32'hFFFF_0000, 5'd1,  32'h0000_0000};
        vecs[9]  = '{1'b1, 1'b1, 5'd3,  32'h0000_0007, 5'd3,  32'h0000_0007};
        vecs[10] = '{1'b1, 1'b1, 5'd4,  32'hFFFF_FFF7, 5'd4,  32'h0000_0007};
        vecs[11] = '{1'b1, 1'b1, 5'd2,  32'h0000_0000, 5'd2,  32'h0000_0000};

        ra = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12};

        reset   = 1'b0;
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        wr_data = '0;
        din     = 4'hF;

        // Reset state with all blink lines high
        repeat (3) tick();
        check("reset_dout", {28'b0, dout}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            rd(ra[k], v);
            check($sformatf("reset_rd_%0d", ra[k]), v, 32'd0);
        end
        reset = 1'b1;
        tick();
        check("bypass_clk1", {28'b0, dout}, 32'd0);
        tick();
        check("bypass_clk2", {28'b0, dout}, 32'h0000_000F);
        din = 4'h0;
        wait_idle("idle_after_bypass", 600);

        // Register map and bus decode
        for (int k = 0; k < 12; k++) begin
            cs      = vecs[k].cs;
            write   = vecs[k].wr;
            addr    = vecs[k].waddr;
            wr_data = vecs[k].wdata;
            tick();
            cs    = 1'b0;
            write = 1'b0;
            rd(vecs[k].raddr, v);
            check($sformatf("vec%0d", k), v, vecs[k].exp);
        end

        // Status register: din_q first, busy one clock later (channel 3 in bypass)
        din = 4'b1000;
        tick();
        rd(5'd12, v);
        check("status_dinq", v, 32'h0000_0008);
        tick();
        rd(5'd12, v);
        check("status_busy", v, 32'h0000_0088);
        check("bypass_ch3", {31'b0, dout[3]}, 32'd1);
        din = 4'b0000;
        wait_idle("idle_after_ch3", 100);

        // Channel 0 full ramp with step 3
        din = 4'b0001;
        for (int n = 1; n <= 1022; n++) begin
            tick();
            rd(5'd8, v);
            if (n == 5)  check("ch0_lvl_n5", v, 32'd0);
            if (n == 6)  check("ch0_lvl_n6", v, 32'd1);
            if (n == 1021) begin
                check("ch0_lvl_n1021", v, 32'd254);
                rd(5'd12, v);
                check("ch0_busy_n1021", {31'b0, v[4]}, 32'd1);
            end
            if (n == 1022) begin
                check("ch0_lvl_n1022", v, 32'd255);
                rd(5'd12, v);
                check("ch0_busy_n1022", {31'b0, v[4]}, 32'd0);
            end
        end
        repeat (2) tick();
        cnt = 0;
        repeat (255) begin
            tick();
            if (dout[0]) cnt++;
        end
        check("ch0_full_duty", cnt, 32'd255);

        // Channel 1 reversal at level 100 with step 0
        din = 4'b0011;
        wait_level("ch1_reach_100", 5'd9, 32'd100, 400);
        din = 4'b0001;
        for (int n = 1; n <= 103; n++) begin
            tick();
            rd(5'd9, v);
            if (n == 1)   check("rev_n1", v, 32'd101);
            if (n == 2)   check("rev_n2", v, 32'd101);
            if (n == 3)   check("rev_n3", v, 32'd100);
            if (n == 102) check("rev_n102", v, 32'd1);
            if (n == 103) begin
                check("rev_n103", v, 32'd0);
                rd(5'd12, v);
                check("rev_busy_off", {31'b0, v[5]}, 32'd0);
            end
        end

        // Channel 2 frozen at level 64 for a duty measurement
        din = 4'b0101;
        wait_level("ch2_reach_63", 5'd10, 32'd63, 400);
        wr(5'd2, 32'h0000_FFFF);
        rd(5'd10, v);
        check("ch2_frozen_64", v, 32'd64);
        repeat (3) tick();
        cnt = 0;
        repeat (255) begin
            tick();
            if (dout[2]) cnt++;
        end
        check("ch2_duty_64", cnt, 32'd64);
        rd(5'd10, v);
        check("ch2_still_64", v, 32'd64);

        // Reset mid-ramp on channel 1 at level 37
        din = 4'b0111;
        wait_level("ch1_reach_37", 5'd9, 32'd37, 400);
        reset = 1'b0;
        #1;
        check("midreset_dout", {28'b0, dout}, 32'd0);
        rd(5'd9, v);
        check("midreset_lvl", v, 32'd0);
        rd(5'd2, v);
        check("midreset_step2", v, 32'd0);
        tick();
        reset = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            tick();
            if (n == 2) begin
                rd(5'd12, v);
                check("restart_busy", {31'b0, v[5]}, 32'd1);
                rd(5'd9, v);
                check("restart_lvl0", v, 32'd0);
            end
            if (n == 3) begin
                rd(5'd9, v);
                check("restart_lvl1", v, 32'd1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
